// File: rtl/fp_mul_seq.sv
// fp_mul_seq -- multi-cycle floating-point multiplier with valid/ready handshakes.
//
// Operands use the layout {sign, exponent[EXP_W], fraction[MAN_W]}. An accepted
// pair is classified for special values, then multiplied with a 1-bit-per-cycle
// shift-add datapath. The product is normalised, range-checked and packed. Rounding
// truncates toward zero, and denormal operands are flushed to zero.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready is high only while idle
//   a, b              operand words (W = 1+EXP_W+MAN_W bits)
//   out_valid/out_ready result handshake; result/status are held until the transfer
//   result            product word
//   status            classification: 0 valid, 1 +inf, 2 -inf, 3 NaN, 4 overflow, 5 underflow
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]         status
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;          // significand width including hidden 1
  localparam int PW = 2 * SW;             // full product width
  localparam int CW = $clog2(SW + 1);
  localparam int EW = EXP_W + 2;          // exponent arithmetic width (two's complement)

  localparam logic [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic [EW-1:0] E_MAX  = EW'((2**EXP_W) - 1);

  localparam logic [2:0] ST_VALID   = 3'd0;
  localparam logic [2:0] ST_POS_INF = 3'd1;
  localparam logic [2:0] ST_NEG_INF = 3'd2;
  localparam logic [2:0] ST_NAN     = 3'd3;
  localparam logic [2:0] ST_OVF     = 3'd4;
  localparam logic [2:0] ST_UNF     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   mcand_q, mcand_d;      // multiplicand, shifted left each step
  logic [SW-1:0]   mplier_q, mplier_d;    // multiplier, shifted right each step
  logic [PW-1:0]   p_q, p_d;              // product accumulator
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    result_q, result_d;
  logic [2:0]      status_q, status_d;
  logic            out_valid_q, out_valid_d;

  // Operand fields and special-value classification (from registered operands)
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               spec_nan, spec_inf, spec_zero, is_special;

  always_comb begin
    sa = a_q[W-1];
    sb = b_q[W-1];
    ea = a_q[W-2 -: EXP_W];
    eb = b_q[W-2 -: EXP_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && !(|fa);
    b_inf  = (&eb) && !(|fb);
    // Exponent zero covers both true zero and denormals, which flush to zero
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    spec_nan   = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    spec_inf   = a_inf || b_inf;
    spec_zero  = a_zero || b_zero;
    is_special = spec_nan || spec_inf || spec_zero;
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      status_q    <= ST_VALID;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CHECK;
      S_CHECK: state_d = is_special ? S_DONE : S_MUL;
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  logic [EW-1:0]    e_n;
  logic [MAN_W-1:0] frac_n;

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    result_d    = result_q;
    status_d    = status_q;
    out_valid_d = 1'b0;
    e_n         = exp_q;
    frac_n      = p_q[PW-3 -: MAN_W];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
        end
      end

      S_CHECK: begin
        sign_d = sa ^ sb;
        exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS_E;
        if (spec_nan) begin
          result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          status_d = ST_NAN;
        end else if (spec_inf) begin
          result_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          // Status follows the first infinite operand's sign, a taking precedence
          if (a_inf) status_d = sa ? ST_NEG_INF : ST_POS_INF;
          else       status_d = sb ? ST_NEG_INF : ST_POS_INF;
        end else if (spec_zero) begin
          result_d = {sa ^ sb, {(W-1){1'b0}}};
          status_d = ST_VALID;
        end else begin
          mcand_d  = {{SW{1'b0}}, 1'b1, fa};
          mplier_d = {1'b1, fb};
          p_d      = '0;
          cnt_d    = CW'(SW);
        end
      end

      S_MUL: begin
        if (mplier_q[0]) p_d = p_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end

      S_NORM: begin
        // Product of two [1,2) significands lies in [1,4); top bit set means >= 2
        if (p_q[PW-1]) begin
          e_n    = exp_q + EW'(1);
          frac_n = p_q[PW-2 -: MAN_W];
        end else begin
          e_n    = exp_q;
          frac_n = p_q[PW-3 -: MAN_W];
        end
        if (!e_n[EW-1] && (e_n >= E_MAX)) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          status_d = ST_OVF;
        end else if (e_n[EW-1] || (e_n == '0)) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          status_d = ST_UNF;
        end else begin
          result_d = {sign_q, e_n[EXP_W-1:0], frac_n};
          status_d = ST_VALID;
        end
      end

      S_DONE: begin
        // out_valid rises one cycle after entering DONE and drops on the transfer edge
        out_valid_d = !(out_valid_q && out_ready);
      end

      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = out_valid_q;
    result    = result_q;
    status    = status_q;
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  status;

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  st;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp_v);
    end
  endtask

  // Reference model: plain integer arithmetic on the IEEE single-precision rules
  function automatic void ref_mul(input logic [31:0] ra, input logic [31:0] rb,
                                  output logic [31:0] r, output logic [2:0] st,
                                  output int lat);
    int ea, eb, e;
    logic sa, sb, s;
    logic [22:0] fa, fb, frac;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned ma, mb, p;
    sa = ra[31]; sb = rb[31]; s = sa ^ sb;
    ea = int'(ra[30:23]); eb = int'(rb[30:23]);
    fa = ra[22:0]; fb = rb[22:0];
    a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0); b_zero = (eb == 0);
    lat = 2;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = 32'h7FC00000; st = 3'd3;
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'h0};
      if (a_inf) st = sa ? 3'd2 : 3'd1;
      else       st = sb ? 3'd2 : 3'd1;
    end else if (a_zero || b_zero) begin
      r = {s, 31'h0}; st = 3'd0;
    end else begin
      lat = 27;
      ma = 64'h800000 + 64'(fa);
      mb = 64'h800000 + 64'(fb);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        e = e + 1;
        frac = 23'(p >> 24);
      end else begin
        frac = 23'(p >> 23);
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; st = 3'd4;
      end else if (e <= 0) begin
        r = {s, 31'h0}; st = 3'd5;
      end else begin
        r = {s, 8'(e), frac}; st = 3'd0;
      end
    end
  endfunction

  // Issue one operand pair, wait (bounded) for the result, then take it
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                       output logic [31:0] r, output logic [2:0] st, output int lat);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;   // later operand changes must not matter
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
    check("out_valid_seen", 32'(out_valid), 32'd1);
    r = result; st = status;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, er, ra, rb;
    logic [2:0]  st, est;
    int          lat, elat, hits;
    logic [7:0]  ea_r, eb_r;

    tbl[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'd0, 27};
    tbl[1] = '{32'hC0000000, 32'h3F400000, 32'hBFC00000, 3'd0, 27};
    tbl[2] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'd0, 27};
    tbl[3] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'd4, 27};
    tbl[4] = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'd5, 27};
    tbl[5] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'd2, 2};
    tbl[6] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'd3, 2};
    tbl[7] = '{32'h80400000, 32'h3F800000, 32'h80000000, 3'd0, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_status", 32'(status), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].a, tbl[i].b, r, st, lat);
      $display("vec %0d: a=%08h b=%08h -> result=%08h status=%0d lat=%0d",
               i, tbl[i].a, tbl[i].b, r, st, lat);
      check("tbl_result", r, tbl[i].res);
      check("tbl_status", 32'(st), 32'(tbl[i].st));
      check("tbl_latency", 32'(lat), 32'(tbl[i].lat));
    end

    // Randomized against the reference model
    for (int i = 0; i < 150; i++) begin
      ea_r = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(60, 195));
      eb_r = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(60, 195));
      ra = {1'($urandom), ea_r, 23'($urandom)};
      rb = {1'($urandom), eb_r, ($urandom_range(0, 9) == 0) ? 23'h0 : 23'($urandom)};
      ref_mul(ra, rb, er, est, elat);
      issue(ra, rb, r, st, lat);
      $display("rnd %0d: a=%08h b=%08h -> result=%08h status=%0d lat=%0d",
               i, ra, rb, r, st, lat);
      check("rnd_result", r, er);
      check("rnd_status", 32'(st), 32'(est));
      check("rnd_latency", 32'(lat), 32'(elat));
    end

    // Backpressure: result held, busy inputs ignored until one cycle after transfer
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
    check("bp_first_latency", 32'(lat), 32'd27);
    in_valid = 1'b1; a = 32'h40400000; b = 32'h40800000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_result", result, 32'h40400000);
      check("bp_hold_status", 32'(status), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_busy_in_ready", 32'(in_ready), 32'd0);
    end
    $display("bp: result held at %08h for 10 cycles", result);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_xfer_in_ready", 32'(in_ready), 32'd1);
    check("bp_after_xfer_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
    $display("bp: second op result=%08h status=%0d lat=%0d", result, status, lat);
    check("bp_second_latency", 32'(lat), 32'd27);
    check("bp_second_result", result, 32'h41400000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of MUL aborts the operation
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hits = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    $display("midrst: out_valid high on %0d cycles after abort", hits);
    check("midrst_no_result", 32'(hits), 32'd0);
    ref_mul(32'hC0000000, 32'h3F400000, er, est, elat);
    issue(32'hC0000000, 32'h3F400000, r, st, lat);
    $display("midrst: next op result=%08h status=%0d lat=%0d", r, st, lat);
    check("midrst_next_result", r, er);
    check("midrst_next_latency", 32'(lat), 32'(elat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
